dmem_responder: RTL
===================

# dmem_responder

Data-memory responder for the core's `d_*` load/store port. It terminates the request/ready handshake the core initiates and holds a word-organised SRAM with byte-enable writes. Read and write wait states are programmable, so the pipeline stall paths can be exercised and slower memories modelled. It sits between the core's data port and the system memory map, at base address `BASE_ADDR`.

## Interface
- `DEPTH`, 4096: memory size in 32-bit words; power of two.
- `BASE_ADDR`, 32'h0001_0000: byte address of word 0; aligned to `DEPTH*4`.
- `RD_WAIT`, 1: extra cycles between read acceptance and `d_rd_ready`; range 0..15.
- `WR_WAIT`, 0: extra cycles between write acceptance and `d_wr_ready`; range 0..15.
- `clk` in 1: the only clock. All logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `d_addr` in 32: byte address. Stable while a request is pending.
- `d_rd_req` in 1: read request level. Held until the cycle `d_rd_ready`=1.
- `d_rd_ready` out 1: read completion, one-cycle pulse.
- `d_rd_data` out 32: full aligned word. Valid in the cycle `d_rd_ready`=1; the core extracts bytes and halves.
- `d_wr_req` in 1: write request level. Held until the cycle `d_wr_ready`=1.
- `d_wr_ready` out 1: write completion, one-cycle pulse.
- `d_be` in 4: byte enables for writes; bit i selects `d_wr_data[8i+7:8i]`.
- `d_wr_data` in 32: write data, already lane-aligned by the initiator.
- `d_err` out 1: only present with `DMEM_RANGE_CHK_EN`. One-cycle pulse with the ready of an out-of-range access.

## Operation
- Word index is `(d_addr - BASE_ADDR) >> 2`. `d_addr[1:0]` is ignored for indexing.
- FSM states:
  - IDLE: no transaction in progress.
  - WAIT: a wait-state counter `cnt` (4 bits) is running.
  - ACK: the ready pulse for the current transaction is being driven.
- IDLE transitions:
  - `d_wr_req`=1 → latch kind=WR. Load `cnt` with `WR_WAIT`. Go to WAIT if `WR_WAIT`>0, else ACK.
  - else `d_rd_req`=1 → latch kind=RD. Load `cnt` with `RD_WAIT`. Capture `mem[idx]` into the `d_rd_data` register. Go to WAIT or ACK by the same rule.
- Priority: write wins when both requests are high in IDLE. The read stays pending and is accepted in IDLE after the write's ACK.
- WAIT: decrement `cnt`; go to ACK when `cnt`==1.
- ACK:
  - Drive the ready that matches kind; the other ready stays 0.
  - For WR, write each byte lane with `d_be[i]`=1 at the closing edge of this cycle. Lanes with `d_be[i]`=0 are untouched.
  - Next state is always IDLE.
  - A request still high in that IDLE cycle is treated as a new transaction. This covers back-to-back loads, where the core re-asserts `d_rd_req` in the same cycle it sees ready.
- Requests that drop before ready are a protocol violation. Behaviour is undefined; no checking is required.
- Memory contents are not reset. Initial contents are X.

## Timing
- Reset values: `d_rd_ready`=0, `d_wr_ready`=0, `d_rd_data`=0, `d_err`=0, state IDLE, `cnt`=0.
- Request first high in IDLE cycle N → ready high in cycle N+1+WAIT, where WAIT is `RD_WAIT` or `WR_WAIT`.
- Minimum spacing between two readies is WAIT+2 cycles.
- Read data reflects every write whose ACK cycle precedes the read's IDLE acceptance cycle. Write-then-read to the same address therefore returns the new data.
- Ready and `d_rd_data` are registered; there is no combinational path from inputs to outputs.
- `rst`=1 in any state → the next cycle is IDLE with all outputs at reset values.
  - A write whose ACK has not yet closed is discarded.
  - A read in flight is dropped without a ready pulse.
- `cnt` arithmetic is 4-bit unsigned. WAIT values above 15 are illegal; an elaboration-time check is required.

## Configuration
- `DMEM_RANGE_CHK_EN` defined:
  - Accesses with `d_addr - BASE_ADDR >= DEPTH*4`, unsigned, still complete with normal timing.
  - Out-of-range writes leave memory unchanged. Out-of-range reads return 32'h0.
  - `d_err` pulses with the ready.
- `DMEM_RANGE_CHK_EN` undefined:
  - No `d_err` port.
  - The index is truncated to `$clog2(DEPTH)` bits, so out-of-range addresses alias into memory.

## Test plan
- `RD_WAIT`=1: write 32'hA5A5_1234 to `BASE_ADDR`+8 with `d_be`=4'hF, then read it → `d_wr_ready` one cycle after acceptance, `d_rd_ready` two cycles after read acceptance, `d_rd_data`=32'hA5A5_1234.
- Byte lanes: preload 32'h1122_3344 at +0. Write 32'hAB00_0000 with `d_be`=4'h8, then 32'h0000_CD00 with `d_be`=4'h2. Read → 32'hAB22_CD44.
- Back-to-back reads with `RD_WAIT`=0: hold `d_rd_req` high through ready while stepping the address +0 → +4 → readies in cycles N+1 and N+3, each with the correct word.
- Simultaneous `d_wr_req` and `d_rd_req` to the same address, writing 32'hDEAD_BEEF → write ready first, then read ready returning 32'hDEAD_BEEF.
- `WR_WAIT`=3: assert `rst` during WAIT → no ready pulse, state IDLE, memory word unchanged.
- With `DMEM_RANGE_CHK_EN`: read `BASE_ADDR`+`DEPTH*4` → `d_rd_ready`=1, `d_rd_data`=0, `d_err`=1 for one cycle. Write to the same address → word 0 is unchanged.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the core d_* load/store port: word SRAM with byte-enable
// writes and programmable wait states. Optional range check via DMEM_RANGE_CHK_EN.
module dmem_responder #(
  parameter int unsigned DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter int unsigned RD_WAIT   = 1,
  parameter int unsigned WR_WAIT   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_addr,
  input  logic        d_rd_req,
  output logic        d_rd_ready,
  output logic [31:0] d_rd_data,
  input  logic        d_wr_req,
  output logic        d_wr_ready,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_wr_data
`ifdef DMEM_RANGE_CHK_EN
  ,
  output logic        d_err
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0]  RD_CNT = 4'(RD_WAIT);
  localparam logic [3:0]  WR_CNT = 4'(WR_WAIT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  localparam logic KIND_RD = 1'b0;
  localparam logic KIND_WR = 1'b1;

  // Elaboration-time parameter legality
  if (RD_WAIT > 15 || WR_WAIT > 15) begin : g_bad_wait
    $error("dmem_responder: RD_WAIT/WR_WAIT must be in 0..15");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("dmem_responder: DEPTH must be a power of two >= 2");
  end
  if (BASE_ADDR[AW+1:0] != '0) begin : g_bad_base
    $error("dmem_responder: BASE_ADDR must be aligned to DEPTH*4");
  end

  logic [31:0]   mem [DEPTH];
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          in_range;

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       kind_q, kind_d;
  logic       rd_capture;
  logic       mem_we;

  assign off = d_addr - BASE_ADDR;
  assign idx = off[AW+1:2];

`ifdef DMEM_RANGE_CHK_EN
  logic unused_off;
  assign in_range   = off < 32'(DEPTH * 4);
  assign unused_off = ^off[1:0];
`else
  // Upper offset bits are dropped so out-of-range addresses alias into memory
  logic unused_off;
  assign in_range   = 1'b1;
  assign unused_off = ^{off[31:AW+2], off[1:0]};
`endif

  // Next-state logic; write wins over read when both are requested in IDLE
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    kind_d     = kind_q;
    rd_capture = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (d_wr_req) begin
          kind_d  = KIND_WR;
          cnt_d   = WR_CNT;
          state_d = (WR_CNT != 4'd0) ? S_WAIT : S_ACK;
        end else if (d_rd_req) begin
          kind_d     = KIND_RD;
          cnt_d      = RD_CNT;
          rd_capture = 1'b1;
          state_d    = (RD_CNT != 4'd0) ? S_WAIT : S_ACK;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_ACK;
      end
      S_ACK: begin
        state_d = S_IDLE;
        mem_we  = (kind_q == KIND_WR);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; ready is high exactly in the ACK cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      kind_q     <= KIND_RD;
      d_rd_ready <= 1'b0;
      d_wr_ready <= 1'b0;
      d_rd_data  <= 32'h0;
`ifdef DMEM_RANGE_CHK_EN
      d_err      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      kind_q     <= kind_d;
      d_rd_ready <= (state_d == S_ACK) && (kind_d == KIND_RD);
      d_wr_ready <= (state_d == S_ACK) && (kind_d == KIND_WR);
      if (rd_capture) d_rd_data <= in_range ? mem[idx] : 32'h0;
`ifdef DMEM_RANGE_CHK_EN
      d_err      <= (state_d == S_ACK) && !in_range;
`endif
    end
  end

  // Byte-lane write at the closing edge of the write's ACK cycle; no reset on storage
  always_ff @(posedge clk) begin
    if (!rst && mem_we && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (d_be[i]) mem[idx][8*i +: 8] <= d_wr_data[8*i +: 8];
      end
    end
  end

endmodule
